// File: rtl/br_pkg.sv
// Shared types for the EX-stage branch resolver:
// branch class codes and the IF->ID->EX prediction slot.
package br_pkg;

    localparam int BR_XLEN = 32;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    typedef struct packed {
        logic               valid;
        logic [BR_XLEN-1:0] pc;
        logic               pred_taken;
        logic [BR_XLEN-1:0] pred_target;
    } slot_t;

endpackage

// File: rtl/br_compare.sv
// Branch condition evaluation: class and operands -> taken.
// Unknown class codes resolve as not taken.
module br_compare
    import br_pkg::*;
#(
    parameter int XLEN = BR_XLEN
) (
    input  logic [3:0]      br_type,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = !lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = !ltu;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: carries fetch predictions to EX,
// checks them against the real outcome and emits BTB updates.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN  = BR_XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [XLEN-1:0]  if_pred_target,
    input  logic [3:0]       ex_br_type,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  pc_3,
    output logic             is_branch_3,
    output logic             taken_3,
    output logic             prev_taken_3,
    output logic [XLEN-1:0]  target_3,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    slot_t s1;
    slot_t s2;

    logic            is_cls;
    logic            is_jalr;
    logic            alias_hit;
    logic            dir_miss;
    logic            tgt_miss;
    logic [XLEN-1:0] jalr_sum;

    br_compare #(
        .XLEN (XLEN)
    ) u_cmp (
        .br_type (ex_br_type),
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .taken   (taken_3)
    );

    assign is_cls  = (ex_br_type != BR_NONE)
                  && (ex_br_type <= BR_JALR);
    assign is_jalr = (ex_br_type == BR_JALR);

    assign jalr_sum = ex_rs1 + ex_imm;
    assign target_3 = is_jalr
                    ? (jalr_sum & ~XLEN'(1))
                    : (s2.pc + ex_imm);

    assign pc_3         = s2.pc;
    assign prev_taken_3 = s2.pred_taken;
    assign is_branch_3  = s2.valid & is_cls & !stall;

    // BTB aliased a non-branch as taken: fall through to pc+4
    assign alias_hit = s2.valid & !is_cls & !stall
                     & s2.pred_taken;

    assign dir_miss = (taken_3 != prev_taken_3);
    assign tgt_miss = taken_3 & prev_taken_3
                    & (s2.pred_target != target_3);

    assign mispredict = alias_hit
                      | (is_branch_3 & (dir_miss | tgt_miss));

    assign redirect_pc = taken_3 ? target_3
                                 : (s2.pc + XLEN'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1             <= '0;
            s2             <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (!stall) begin
            if (mispredict) begin
                s1.valid <= 1'b0;
                s2.valid <= 1'b0;
            end else begin
                s2 <= s1;
                s1 <= '{valid:       if_valid,
                        pc:          if_pc,
                        pred_taken:  if_pred_taken,
                        pred_target: if_pred_target};
            end
            if (is_branch_3 && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (is_branch_3 && mispredict
                && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table
// plus squash, stall, saturation and reset sequences.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic [3:0]  ex_br_type;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic [31:0] pc_3;
    logic        is_branch_3;
    logic        taken_3;
    logic        prev_taken_3;
    logic [31:0] target_3;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispredict_cnt;

    int n_chk;
    int n_err;
    int m_bc;
    int m_mc;

    branch_resolve_unit #(
        .XLEN  (32),
        .CNT_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_br_type     (ex_br_type),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_imm         (ex_imm),
        .pc_3           (pc_3),
        .is_branch_3    (is_branch_3),
        .taken_3        (taken_3),
        .prev_taken_3   (prev_taken_3),
        .target_3       (target_3),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic [3:0]  bt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic [31:0] e_rd;
        logic        e_br;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc,
        input logic pt, input logic [31:0] ptg,
        input logic [3:0] bt, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] imm,
        input logic tk, input logic [31:0] tgt,
        input logic mis, input logic [31:0] rd,
        input logic br);
        vec_t r;
        r.v = v;      r.pc = pc;    r.pt = pt;
        r.ptg = ptg;  r.bt = bt;    r.a = a;
        r.b = b;      r.imm = imm;  r.e_tk = tk;
        r.e_tgt = tgt; r.e_mis = mis;
        r.e_rd = rd;  r.e_br = br;
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic br, input logic mis);
        if (br && m_bc < 15) m_bc++;
        if (br && mis && m_mc < 15) m_mc++;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, ".bcnt"}, {28'd0, branch_cnt}, m_bc);
        chk({nm, ".mcnt"}, {28'd0, mispredict_cnt}, m_mc);
    endtask

    task automatic idle_ex();
        ex_br_type = 4'd0;
        ex_rs1 = '0;
        ex_rs2 = '0;
        ex_imm = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        stall = 1'b0;
        idle_ex();
        if_valid = v.v;
        if_pc = v.pc;
        if_pred_taken = v.pt;
        if_pred_target = v.ptg;
        tick();
        if_valid = 1'b0;
        if_pc = '0;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        tick();
        ex_br_type = v.bt;
        ex_rs1 = v.a;
        ex_rs2 = v.b;
        ex_imm = v.imm;
        #1;
        chk({nm, ".isbr"}, {31'd0, is_branch_3}, {31'd0, v.e_br});
        chk({nm, ".taken"}, {31'd0, taken_3}, {31'd0, v.e_tk});
        chk({nm, ".mis"}, {31'd0, mispredict}, {31'd0, v.e_mis});
        chk({nm, ".redir"}, redirect_pc, v.e_rd);
        if (v.v) begin
            chk({nm, ".pc"}, pc_3, v.pc);
            chk({nm, ".prev"}, {31'd0, prev_taken_3},
                {31'd0, v.pt});
        end
        if (v.e_br)
            chk({nm, ".tgt"}, target_3, v.e_tgt);
        tick();
        model(v.e_br, v.e_mis);
        idle_ex();
        #1;
        chk_cnt(nm);
        chk({nm, ".bubble"}, {31'd0, is_branch_3}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_bc = 0;
        m_mc = 0;
        rst = 1'b1;
        stall = 1'b0;
        if_valid = 1'b0;
        if_pc = '0;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        idle_ex();

        //        v pc          pt ptg          bt  a            b            imm          tk tgt          mis rd           br
        tbl[0]  = mk(1, 32'h100, 1, 32'h140, 1, 32'd5, 32'd5, 32'h40, 1, 32'h140, 0, 32'h140, 1);
        tbl[1]  = mk(1, 32'h200, 1, 32'h220, 2, 32'd3, 32'd3, 32'h20, 0, 32'h220, 1, 32'h204, 1);
        tbl[2]  = mk(1, 32'h300, 1, 32'h1000, 8, 32'h1001, 32'd0, 32'd4, 1, 32'h1004, 1, 32'h1004, 1);
        tbl[3]  = mk(1, 32'h400, 0, 32'h0, 3, 32'hFFFFFFFF, 32'd1, 32'h10, 1, 32'h410, 1, 32'h410, 1);
        tbl[4]  = mk(1, 32'h500, 0, 32'h0, 5, 32'hFFFFFFFF, 32'd1, 32'h10, 0, 32'h510, 0, 32'h504, 1);
        tbl[5]  = mk(1, 32'h600, 0, 32'h0, 4, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF8, 1, 32'h5F8, 1, 32'h5F8, 1);
        tbl[6]  = mk(1, 32'h700, 0, 32'h0, 6, 32'd1, 32'hFFFFFFFF, 32'h8, 0, 32'h708, 0, 32'h704, 1);
        tbl[7]  = mk(1, 32'h800, 1, 32'h900, 7, 32'd0, 32'd0, 32'h100, 1, 32'h900, 0, 32'h900, 1);
        tbl[8]  = mk(1, 32'h900, 1, 32'h980, 0, 32'd0, 32'd0, 32'h0, 0, 32'h0, 1, 32'h904, 0);
        tbl[9]  = mk(1, 32'hA00, 0, 32'h0, 12, 32'd0, 32'd0, 32'h10, 0, 32'h0, 0, 32'hA04, 0);
        tbl[10] = mk(1, 32'hFFFFFFF0, 1, 32'h10, 1, 32'd0, 32'd0, 32'h20, 1, 32'h10, 0, 32'h10, 1);
        tbl[11] = mk(0, 32'hB00, 0, 32'h0, 1, 32'd9, 32'd9, 32'h4, 1, 32'h0, 0, 32'hB04, 0);
        tbl[12] = mk(1, 32'hC00, 1, 32'hC80, 2, 32'd1, 32'd2, 32'h40, 1, 32'hC40, 1, 32'hC40, 1);

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("init.isbr", {31'd0, is_branch_3}, 32'd0);
        chk("init.mis", {31'd0, mispredict}, 32'd0);
        chk_cnt("init");

        for (int i = 0; i < 13; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // squash: wrong-path slots must never reach EX
        if_valid = 1'b1;
        if_pc = 32'h200;
        if_pred_taken = 1'b1;
        if_pred_target = 32'h220;
        tick();
        if_pc = 32'h220;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        tick();
        ex_br_type = 4'd2;
        ex_rs1 = 32'd3;
        ex_rs2 = 32'd3;
        ex_imm = 32'h20;
        if_pc = 32'h224;
        #1;
        chk("sq.mis", {31'd0, mispredict}, 32'd1);
        chk("sq.redir", redirect_pc, 32'h204);
        tick();
        model(1'b1, 1'b1);
        ex_br_type = 4'd1;
        ex_rs1 = 32'd5;
        ex_rs2 = 32'd5;
        ex_imm = '0;
        if_pc = 32'h204;
        #1;
        chk("sq.d.isbr", {31'd0, is_branch_3}, 32'd0);
        chk("sq.d.mis", {31'd0, mispredict}, 32'd0);
        chk_cnt("sq");
        tick();
        if_valid = 1'b0;
        if_pc = '0;
        #1;
        chk("sq.e.isbr", {31'd0, is_branch_3}, 32'd0);
        chk("sq.e.mis", {31'd0, mispredict}, 32'd0);
        tick();
        ex_rs1 = 32'd1;
        ex_rs2 = 32'd2;
        ex_imm = 32'h8;
        #1;
        chk("sq.f.pc", pc_3, 32'h204);
        chk("sq.f.isbr", {31'd0, is_branch_3}, 32'd1);
        chk("sq.f.mis", {31'd0, mispredict}, 32'd0);
        tick();
        model(1'b1, 1'b0);
        idle_ex();

        // stall: hold BLT in EX while IF offers junk
        if_valid = 1'b1;
        if_pc = 32'hF00;
        if_pred_taken = 1'b1;
        if_pred_target = 32'hF10;
        tick();
        if_valid = 1'b0;
        if_pc = '0;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        tick();
        stall = 1'b1;
        ex_br_type = 4'd3;
        ex_rs1 = 32'hFFFFFFFF;
        ex_rs2 = 32'd1;
        ex_imm = 32'h10;
        if_valid = 1'b1;
        if_pc = 32'h1234;
        if_pred_taken = 1'b1;
        if_pred_target = 32'h5678;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d.isbr", c),
                {31'd0, is_branch_3}, 32'd0);
            chk($sformatf("st%0d.mis", c),
                {31'd0, mispredict}, 32'd0);
            chk_cnt($sformatf("st%0d", c));
            tick();
        end
        ex_br_type = 4'd5;
        #1;
        chk("st.bltu", {31'd0, taken_3}, 32'd0);
        ex_br_type = 4'd3;
        #1;
        chk("st.blt", {31'd0, taken_3}, 32'd1);
        stall = 1'b0;
        if_valid = 1'b0;
        if_pc = '0;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        #1;
        chk("st.rel.isbr", {31'd0, is_branch_3}, 32'd1);
        chk("st.rel.pc", pc_3, 32'hF00);
        chk("st.rel.mis", {31'd0, mispredict}, 32'd0);
        tick();
        model(1'b1, 1'b0);
        #1;
        chk_cnt("st.rel");
        chk("st.after", {31'd0, is_branch_3}, 32'd0);
        idle_ex();

        // saturation on the 4-bit counters
        for (int k = 0; k < 20; k++)
            run_vec(mk(1, 32'hE00, 1, 32'hE40, 2,
                       32'd7, 32'd7, 32'h40, 0, 32'hE40,
                       1, 32'hE04, 1),
                    $sformatf("sat%0d", k));
        chk("sat.bcnt", {28'd0, branch_cnt}, 32'd15);
        chk("sat.mcnt", {28'd0, mispredict_cnt}, 32'd15);

        // reset beats stall with a live BEQ in EX
        if_valid = 1'b1;
        if_pc = 32'hD00;
        if_pred_taken = 1'b1;
        if_pred_target = 32'hD04;
        tick();
        if_valid = 1'b0;
        if_pc = '0;
        if_pred_taken = 1'b0;
        if_pred_target = '0;
        tick();
        ex_br_type = 4'd1;
        ex_rs1 = 32'd4;
        ex_rs2 = 32'd4;
        ex_imm = 32'h4;
        stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        idle_ex();
        #1;
        chk("rst.isbr", {31'd0, is_branch_3}, 32'd0);
        chk("rst.mis", {31'd0, mispredict}, 32'd0);
        chk("rst.taken", {31'd0, taken_3}, 32'd0);
        chk("rst.prev", {31'd0, prev_taken_3}, 32'd0);
        chk("rst.pc", pc_3, 32'd0);
        chk("rst.tgt", target_3, 32'd0);
        chk("rst.bcnt", {28'd0, branch_cnt}, 32'd0);
        chk("rst.mcnt", {28'd0, mispredict_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule
